// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: pipelined unsigned adder. Each stage adds one SLICE-bit slice plus a registered carry.
// Optional feature macro ADD_PIPE_OVF_EN adds the out_ovf signed-overflow output.
module adder_pipe_nbit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    // WIDTH must be a multiple of SLICE and at least SLICE.
    localparam int NSTAGE = WIDTH / SLICE;

    logic advance;

    // The whole pipe moves in lockstep; bubbles are kept so latency is fixed.
    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : stg
            localparam int LO = gi * SLICE;
            localparam int RW = WIDTH - LO;
            localparam int UW = RW - SLICE;

            logic [RW-1:0]       a_in;
            logic [RW-1:0]       b_in;
            logic                c_in;
            logic                v_in;
            logic [SLICE:0]      add_w;
            logic [LO+SLICE-1:0] s_new;
            logic                v_q, v_d;
            logic                c_q, c_d;
            logic [LO+SLICE-1:0] s_q, s_d;

            // a_in/b_in hold only the operand bits not yet added; this slice sits at the bottom.
            if (gi == 0) begin : src
                assign a_in  = a;
                assign b_in  = b;
                assign c_in  = cin;
                assign v_in  = in_valid;
                assign s_new = add_w[SLICE-1:0];
            end else begin : src
                assign a_in  = stg[gi-1].up.a_q;
                assign b_in  = stg[gi-1].up.b_q;
                assign c_in  = stg[gi-1].c_q;
                assign v_in  = stg[gi-1].v_q;
                assign s_new = {add_w[SLICE-1:0], stg[gi-1].s_q};
            end

            assign add_w = {1'b0, a_in[SLICE-1:0]} + {1'b0, b_in[SLICE-1:0]}
                         + {{SLICE{1'b0}}, c_in};

            always_comb begin
                v_d = v_q;
                c_d = c_q;
                s_d = s_q;
                if (advance) begin
                    v_d = v_in;
                    c_d = add_w[SLICE];
                    s_d = s_new;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else begin
                    v_q <= v_d;
                    c_q <= c_d;
                    s_q <= s_d;
                end
            end

            // Upper operand slices ride along until their own stage.
            if (UW > 0) begin : up
                logic [UW-1:0] a_q, a_d;
                logic [UW-1:0] b_q, b_d;

                always_comb begin
                    a_d = a_q;
                    b_d = b_q;
                    if (advance) begin
                        a_d = a_in[RW-1:SLICE];
                        b_d = b_in[RW-1:SLICE];
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end
            end

`ifdef ADD_PIPE_OVF_EN
            // The operand MSBs reach the last stage through the input skew, so overflow is decided there.
            if (gi == NSTAGE - 1) begin : ovf
                logic ovf_q, ovf_d;

                always_comb begin
                    ovf_d = ovf_q;
                    if (advance) begin
                        ovf_d = (a_in[RW-1] == b_in[RW-1]) && (add_w[SLICE-1] != a_in[RW-1]);
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else begin
                        ovf_q <= ovf_d;
                    end
                end
            end
`endif
        end
    endgenerate

    assign out_valid = stg[NSTAGE-1].v_q;
    assign sum       = {stg[NSTAGE-1].c_q, stg[NSTAGE-1].s_q};
`ifdef ADD_PIPE_OVF_EN
    assign out_ovf   = stg[NSTAGE-1].ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Testbench for adder_pipe_nbit (WIDTH=8, SLICE=2): directed vector table, streaming,
// backpressure and mid-flight reset, with an in-order scoreboard on the output handshake.
module tb_adder_pipe_nbit;
    localparam int WIDTH  = 8;
    localparam int SLICE  = 2;
    localparam int NSTAGE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
`ifdef ADD_PIPE_OVF_EN
    logic             out_ovf;
`endif

    int checks    = 0;
    int errors    = 0;
    int out_count = 0;

    adder_pipe_nbit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef ADD_PIPE_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: transfers are decided at the next rising edge, so look at the handshake on the falling edge.
    logic [WIDTH:0] exp_q[$];
    logic           exp_ovf_q[$];

    always @(negedge clk) begin
        logic [WIDTH:0] e;
        logic           eo;
        if (rst) begin
            exp_q.delete();
            exp_ovf_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_output actual=0x%03h required=no output", sum);
                end else begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("sb_sum", 32'(sum), 32'(e));
`ifdef ADD_PIPE_OVF_EN
                    check("sb_ovf", 32'(out_ovf), 32'(eo));
`endif
                end
                out_count++;
                $display("OUT #%0d sum=0x%03h", out_count, sum);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() != 0) begin
                    check("stall_sum_stable", 32'(sum), 32'(exp_q[0]));
                end
            end
            if (in_valid && in_ready) begin
                e = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                exp_q.push_back(e);
                exp_ovf_q.push_back((a[WIDTH-1] == b[WIDTH-1]) && (e[WIDTH-1] != a[WIDTH-1]));
            end
        end
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH:0]   sum;
        logic             ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        int c0;
        int i;
        int cyc;
        int seen;
        logic acc;
        logic [WIDTH-1:0] pa[8];
        logic [WIDTH-1:0] pb[8];

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 1'b0, 9'h000, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 9'h001, 1'b0};
        vecs[4]  = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
        vecs[6]  = '{8'h7F, 8'h80, 1'b0, 9'h0FF, 1'b0};
        vecs[7]  = '{8'h55, 8'hAA, 1'b1, 9'h100, 1'b0};
        vecs[8]  = '{8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b0};
        vecs[9]  = '{8'h01, 8'h01, 1'b1, 9'h003, 1'b0};
        vecs[10] = '{8'h7F, 8'h7F, 1'b1, 9'h0FF, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef ADD_PIPE_OVF_EN
        check("reset_ovf", 32'(out_ovf), 32'd0);
`endif
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("idle_no_output", 32'(seen), 32'd0);

        // Directed vectors, one at a time, with latency check
        for (int v = 0; v < 11; v++) begin
            a = vecs[v].a; b = vecs[v].b; cin = vecs[v].cin; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("vec%0d_latency", v), 32'(n), 32'(NSTAGE - 1));
            check($sformatf("vec%0d_sum", v), 32'(sum), 32'(vecs[v].sum));
`ifdef ADD_PIPE_OVF_EN
            check($sformatf("vec%0d_ovf", v), 32'(out_ovf), 32'(vecs[v].ovf));
`endif
            tick();
        end

        // Streaming: 16 back-to-back random pairs
        c0 = out_count;
        for (int k = 0; k < 16; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_count != c0 + 16 && n < 40) begin
            tick();
            n++;
        end
        check("stream_count", 32'(out_count - c0), 32'd16);
        check("stream_no_gaps", 32'(n), 32'(NSTAGE));

        // Backpressure: out_ready low for 5 cycles mid-stream
        for (int k = 0; k < 8; k++) begin
            pa[k] = 8'(8'h21 + k * 8'h2B);
            pb[k] = 8'(8'hF0 - k * 8'h17);
        end
        c0 = out_count;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 40) begin
            a = pa[i]; b = pb[i]; cin = 1'(i % 2); in_valid = 1'b1;
            out_ready = !(cyc >= 4 && cyc < 9);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_all_accepted", 32'(i), 32'd8);
        n = 0;
        while (out_count != c0 + 8 && n < 40) begin
            tick();
            n++;
        end
        check("bp_count", 32'(out_count - c0), 32'd8);

        // Reset mid-flight: three pairs in the pipe are discarded
        for (int k = 0; k < 3; k++) begin
            a = 8'(8'h40 + k); b = 8'h01; cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c0 = out_count;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_flush_no_output", 32'(seen), 32'd0);
        check("rst_flush_count", 32'(out_count - c0), 32'd0);
        a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("post_rst_latency", 32'(n), 32'(NSTAGE - 1));
        check("post_rst_sum", 32'(sum), 32'h030);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
